// File: rtl/systolic_seq.sv
// Sequencer for one systolic matrix-multiply pass: loads DIM A-rows then DIM
// B-rows into the skew-FIFO banks, then runs the array for COMPUTE_CYCLES.
// Ports: clk, rst (async, active-high), start, hold, in_valid / in_ready
// (host row handshake), a_en/a_wr_en/a_row and b_en/b_wr_en/b_row (FIFO bank
// control), sys_en (array enable), busy, done (one-cycle completion pulse).
// Optional macro SYSTOLIC_SEQ_PERF_EN adds perf_busy_cycles/perf_stall_cycles.
module systolic_seq #(
    parameter int DIM            = 8,
    parameter int COMPUTE_CYCLES = 3 * DIM - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   hold,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   a_en,
    output logic                   a_wr_en,
    output logic [$clog2(DIM)-1:0] a_row,
    output logic                   b_en,
    output logic                   b_wr_en,
    output logic [$clog2(DIM)-1:0] b_row,
    output logic                   sys_en,
    output logic                   busy,
    output logic                   done
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_busy_cycles,
    output logic [31:0]            perf_stall_cycles
`endif
);

    localparam int RW = $clog2(DIM);
    localparam int CW = $clog2(DIM) + 1;
    localparam int KW = $clog2(COMPUTE_CYCLES) + 1;

    localparam logic [CW-1:0] ROW_LAST = CW'(DIM - 1);
    localparam logic [KW-1:0] CYC_LAST = KW'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] row_cnt;
    logic [KW-1:0] cyc_cnt;
    logic          accept;
    logic          run;

    // in_ready is only ever high in the load states, so this is a load beat.
    assign accept = in_valid & in_ready;
    assign run    = (state == S_COMPUTE) & ~hold;

    assign a_wr_en = (state == S_LOAD_A) & accept;
    assign b_wr_en = (state == S_LOAD_B) & accept;
    assign a_row   = (state == S_LOAD_A) ? row_cnt[RW-1:0] : '0;
    assign b_row   = (state == S_LOAD_B) ? row_cnt[RW-1:0] : '0;
    assign a_en    = run;
    assign b_en    = run;
    assign sys_en  = run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            row_cnt  <= '0;
            cyc_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD_A;
                        row_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    if (accept) begin
                        if (row_cnt == ROW_LAST) begin
                            state   <= S_LOAD_B;
                            row_cnt <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (accept) begin
                        if (row_cnt == ROW_LAST) begin
                            state    <= S_COMPUTE;
                            row_cnt  <= '0;
                            cyc_cnt  <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (!hold) begin
                        if (cyc_cnt == CYC_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic stall;

    assign stall = (((state == S_LOAD_A) || (state == S_LOAD_B)) & ~in_valid)
                 | ((state == S_COMPUTE) & hold);

    // Counters saturate rather than wrap so long runs never read as short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != 32'hFFFF_FFFF))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (stall && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq: per-cycle output comparison against
// a row/cycle-count reference model, plus per-pass totals and latency checks.
module tb_systolic_seq;

    localparam int DIM = 8;
    localparam int CC  = 3 * DIM - 2;
    localparam int RW  = $clog2(DIM);
    localparam int VW  = 8 + 2 * RW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic          in_valid;
    logic          in_ready;
    logic          a_en;
    logic          a_wr_en;
    logic [RW-1:0] a_row;
    logic          b_en;
    logic          b_wr_en;
    logic [RW-1:0] b_row;
    logic          sys_en;
    logic          busy;
    logic          done;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: progress of the pass in rows and enabled cycles.
    bit m_act = 1'b0;
    int m_a   = 0;
    int m_b   = 0;
    int m_en  = 0;
    int mp_busy  = 0;
    int mp_stall = 0;

    // Per-pass observations of the DUT.
    int o_awr, o_bwr, o_en, o_done, o_done_n, step_n;

    systolic_seq #(.DIM(DIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold     (hold),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_en     (a_en),
        .a_wr_en  (a_wr_en),
        .a_row    (a_row),
        .b_en     (b_en),
        .b_wr_en  (b_wr_en),
        .b_row    (b_row),
        .sys_en   (sys_en),
        .busy     (busy),
        .done     (done)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // 0 idle, 1 loading A, 2 loading B, 3 computing, 4 done
    function automatic int phase();
        if (!m_act)        return 0;
        else if (m_a < DIM) return 1;
        else if (m_b < DIM) return 2;
        else if (m_en < CC) return 3;
        else                return 4;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {in_ready, a_en, a_wr_en, a_row, b_en, b_wr_en, b_row,
                sys_en, busy, done};
    endfunction

    task automatic model_reset();
        m_act    = 1'b0;
        m_a      = 0;
        m_b      = 0;
        m_en     = 0;
        mp_busy  = 0;
        mp_stall = 0;
    endtask

    task automatic check_perf(input string tag);
`ifdef SYSTOLIC_SEQ_PERF_EN
        checks++;
        assert (perf_busy_cycles === 32'(mp_busy)) else begin
            failures++;
            $error("FAIL %s perf_busy obs=%0d exp=%0d", tag,
                   perf_busy_cycles, mp_busy);
        end
        checks++;
        assert (perf_stall_cycles === 32'(mp_stall)) else begin
            failures++;
            $error("FAIL %s perf_stall obs=%0d exp=%0d", tag,
                   perf_stall_cycles, mp_stall);
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic step(input bit s, input bit v, input bit h);
        logic          e_rdy, e_en, e_awr, e_bwr, e_busy, e_done;
        logic [RW-1:0] e_arow, e_brow;
        logic [VW-1:0] e_vec;
        logic [VW-1:0] o_vec;
        int            ph;
        @(negedge clk);
        start    = s;
        in_valid = v;
        hold     = h;
        #1;
        ph     = phase();
        e_rdy  = 1'b0;
        e_en   = 1'b0;
        e_awr  = 1'b0;
        e_bwr  = 1'b0;
        e_busy = (ph != 0);
        e_done = (ph == 4);
        e_arow = '0;
        e_brow = '0;
        if (ph == 1) begin
            e_rdy  = 1'b1;
            e_awr  = v;
            e_arow = RW'(m_a);
        end else if (ph == 2) begin
            e_rdy  = 1'b1;
            e_bwr  = v;
            e_brow = RW'(m_b);
        end else if (ph == 3) begin
            e_en = ~h;
        end
        e_vec = {e_rdy, e_en, e_awr, e_arow, e_en, e_bwr, e_brow,
                 e_en, e_busy, e_done};
        o_vec = obs_vec();
        checks++;
        assert (o_vec === e_vec) else begin
            failures++;
            $error("FAIL outputs ph=%0d obs=%b exp=%b", ph, o_vec, e_vec);
        end
        check_perf("cycle");
        o_awr += int'(a_wr_en);
        o_bwr += int'(b_wr_en);
        o_en  += int'(sys_en);
        if (done === 1'b1) begin
            o_done++;
            o_done_n = step_n;
        end
        step_n++;
        // Advance the model to the state after the coming rising edge.
        if (ph != 0) mp_busy++;
        if (((ph == 1 || ph == 2) && !v) || (ph == 3 && h)) mp_stall++;
        case (ph)
            0: if (s) begin
                m_act    = 1'b1;
                m_a      = 0;
                m_b      = 0;
                m_en     = 0;
                mp_busy  = 0;
                mp_stall = 0;
            end
            1: if (v) m_a++;
            2: if (v) m_b++;
            3: if (!h) m_en++;
            default: m_act = 1'b0;
        endcase
    endtask

    // vmode: 0 always valid, 1 random, 2 A-load pattern 1,0,0 repeating,
    // 3 first three load cycles stalled.
    task automatic run_pass(input int vmode, input int hold_at,
                            input int hold_len, input bit noise,
                            input string tag);
        int lc    = 0;
        int n     = 0;
        int hleft = hold_len;
        bit s, v, h;
        int ph;
        o_awr    = 0;
        o_bwr    = 0;
        o_en     = 0;
        o_done   = 0;
        o_done_n = -1;
        step_n   = 0;
        step(1'b1, noise, noise);
        while (m_act && n < 400) begin
            ph = phase();
            s  = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            v  = 1'b0;
            h  = 1'b0;
            if (ph == 1 || ph == 2) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = ($urandom_range(0, 99) < 60);
                    2:       v = (ph == 1) ? (lc % 3 == 0) : 1'b1;
                    default: v = (lc >= 3);
                endcase
                lc++;
                if (noise) h = $urandom_range(0, 1) == 1;
            end else if (ph == 3) begin
                if (hleft > 0 && m_en >= hold_at) begin
                    h = 1'b1;
                    hleft--;
                end
                if (noise) v = $urandom_range(0, 1) == 1;
            end
            step(s, v, h);
            n++;
        end
        checks++;
        assert (!m_act) else begin
            failures++;
            $error("FAIL %s timeout obs=%0d exp=<400", tag, n);
        end
        checks++;
        assert (o_awr == DIM && o_bwr == DIM) else begin
            failures++;
            $error("FAIL %s writes obs=%0d/%0d exp=%0d", tag, o_awr, o_bwr, DIM);
        end
        checks++;
        assert (o_en == CC) else begin
            failures++;
            $error("FAIL %s sys_en obs=%0d exp=%0d", tag, o_en, CC);
        end
        checks++;
        assert (o_done == 1 && o_done_n == 1 + lc + CC + hold_len) else begin
            failures++;
            $error("FAIL %s done obs=%0d@%0d exp=1@%0d", tag, o_done,
                   o_done_n, 1 + lc + CC + hold_len);
        end
        // First idle cycle after the pass: busy must have fallen.
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (obs_vec() === '0) else begin
            failures++;
            $error("FAIL reset obs=%b exp=0", obs_vec());
        end
        check_perf("reset");
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);

        // Abort mid LOAD_B with three B rows already written.
        step(1'b1, 1'b0, 1'b0);
        repeat (DIM + 3) step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        assert (obs_vec() === '0) else begin
            failures++;
            $error("FAIL midreset obs=%b exp=0", obs_vec());
        end
        model_reset();
        check_perf("midreset");
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);

        run_pass(0, 0, 0, 1'b0, "nominal");
        run_pass(2, 0, 0, 1'b0, "backpressure");
        run_pass(0, 10, 5, 1'b0, "hold");
        run_pass(1, 7, 3, 1'b1, "ignored");
        run_pass(3, 10, 5, 1'b0, "perf");
`ifdef SYSTOLIC_SEQ_PERF_EN
        checks++;
        assert (perf_stall_cycles === 32'd8 && perf_busy_cycles === 32'd47)
        else begin
            failures++;
            $error("FAIL perf_fixed obs=%0d/%0d exp=8/47",
                   perf_stall_cycles, perf_busy_cycles);
        end
`endif
        for (int i = 0; i < 3; i++)
            run_pass(1, $urandom_range(0, CC - 1), $urandom_range(0, 6),
                     1'b1, "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for one systolic matrix-multiply pass.
- Accepts a stream of DIM A-rows followed by DIM B-rows from the host side over a valid/ready handshake.
- Steers each row into the A/B skew-FIFO banks by driving their enable, write-enable and row-select.
- Then runs the array and FIFOs for a fixed number of compute cycles and reports completion.

Parameters:
- DIM, 8, matrix dimension; number of rows per operand.
- COMPUTE_CYCLES, 3*DIM-2, en-cycles needed to shift all skewed data through the array.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a pass; sampled only in IDLE.
- hold  input  1  pause compute; freezes the counter and deasserts en.
- in_valid  input  1  host row available.
- in_ready  output  1  sequencer accepts a row this cycle.
- a_en  output  1  shift enable to A FIFO bank.
- a_wr_en  output  1  write enable to A FIFO bank.
- a_row  output  $clog2(DIM)  A row select.
- b_en  output  1  shift enable to B FIFO bank.
- b_wr_en  output  1  write enable to B FIFO bank.
- b_row  output  $clog2(DIM)  B row select.
- sys_en  output  1  systolic array compute enable.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE, counters=0. All outputs 0: in_ready, a_*, b_*, sys_en, busy, done.
- Reset asserted mid-pass aborts immediately to IDLE. No done pulse.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, DONE.
- IDLE:
  - start=1 -> LOAD_A next cycle, row_cnt=0.
  - start in any other state is ignored.
- LOAD_A:
  - in_ready=1 (registered, valid the first LOAD_A cycle).
  - Row accepted when in_valid & in_ready.
  - On acceptance: a_wr_en=1, a_row=row_cnt, row_cnt++. All outputs combinational from state/counter/in_valid, same cycle as acceptance.
  - a_en=0 during load.
  - Acceptance of row DIM-1 -> LOAD_B, row_cnt=0.
  - in_valid=0 -> no write, counter held; wait indefinitely.
- LOAD_B: identical to LOAD_A, using b_wr_en/b_row. Last accepted row -> COMPUTE, cyc_cnt=0.
- a_row/b_row: equal row_cnt in their own load state, 0 otherwise.
- COMPUTE:
  - in_ready=0.
  - hold=0: a_en=b_en=sys_en=1, cyc_cnt++.
  - hold=1: a_en, b_en, sys_en all 0; cyc_cnt frozen.
  - Leaves COMPUTE on the cycle cyc_cnt==COMPUTE_CYCLES-1 with hold=0 -> DONE. Exactly COMPUTE_CYCLES enabled cycles occur in total.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- busy: registered, 1 in LOAD_A, LOAD_B, COMPUTE, DONE.
- Counters wrap-free: row_cnt width $clog2(DIM)+1; cyc_cnt width $clog2(COMPUTE_CYCLES)+1.
- hold outside COMPUTE is ignored.
- in_valid while in_ready=0 is ignored; no write.
- No back-to-back pass overlap: start during DONE is ignored. The earliest new pass starts from IDLE on the following cycle.

Optional Feature:
- Macro SYSTOLIC_SEQ_PERF_EN.
- With the macro defined, adds outputs:
  - perf_busy_cycles [31:0]: cycles with busy=1.
  - perf_stall_cycles [31:0]: cycles in LOAD with in_valid=0, plus cycles in COMPUTE with hold=1.
  - Both saturate at 32'hFFFFFFFF.
  - Both cleared by rst and on start acceptance in IDLE.
- Without the macro, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 mid-LOAD_B (DIM=8, row_cnt=3), release -> all outputs 0, state IDLE. A subsequent start gives a clean pass with a_row starting at 0.
- Nominal pass: start, then 16 back-to-back in_valid beats.
  - a_wr_en on beats 0-7 with a_row 0..7; b_wr_en on beats 8-15 with b_row 0..7.
  - Then sys_en=1 for exactly 22 consecutive cycles.
  - done pulses once on the cycle after the last sys_en. busy falls the cycle after that.
- Load backpressure: in_valid toggles 1,0,0,1,... during LOAD_A.
  - Writes occur only on in_valid=1 cycles; a_row increments only on them.
  - Still exactly 8 A writes.
- Compute hold: hold=1 for 5 cycles starting at compute cycle 10.
  - sys_en, a_en, b_en low during those 5 cycles.
  - Enabled cycles total 22; done arrives 5 cycles later than nominal.
- Ignored inputs:
  - start pulses during LOAD_A, COMPUTE and DONE -> no restart, pass completes unchanged.
  - in_valid during COMPUTE -> no a_wr_en/b_wr_en.
- Perf (macro defined): nominal pass with 3 load stalls and 5 hold cycles -> perf_stall_cycles=8.
  - perf_busy_cycles = 16+22+1+3+5 = 47.
